// File: rtl/aes_pkg.sv
// Shared AES control definitions: round count, key-index width, decrypt FSM
// states and the per-state strobe decode.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    LOAD  = 3'd2,
    ROUND = 3'd3,
    LAST  = 3'd4,
    DONE  = 3'd5
  } dec_state_t;

  typedef struct packed {
    logic genk;
    logic ld_blk;
    logic ark;
    logic inv_mix;
    logic rnd_en;
    logic busy;
    logic done;
  } dec_ctl_t;

  function automatic dec_ctl_t ctl_decode(input dec_state_t s);
    dec_ctl_t c;
    c         = '0;
    c.genk    = (s == KEXP);
    c.ld_blk  = (s == LOAD);
    c.ark     = (s == LOAD);
    c.inv_mix = (s == ROUND);
    c.rnd_en  = (s == LOAD) || (s == ROUND) || (s == LAST);
    c.busy    = (s == KEXP) || (s == LOAD) || (s == ROUND) || (s == LAST);
    c.done    = (s == DONE);
    return c;
  endfunction

endpackage

// File: rtl/aes_dec_cu_if.sv
// Request/strobe bundle between the decrypt control unit and its datapath/key store.
interface aes_dec_cu_if #(
  parameter int KW = aes_pkg::KW
) ();
  logic          start;
  logic          key_new;
  logic          genk;
  logic [KW-1:0] kidx;
  logic          ld_blk;
  logic          ark;
  logic          inv_mix;
  logic          rnd_en;
  logic          busy;
  logic          done;
  logic          keys_valid;

  modport master (
    output start, key_new,
    input  genk, kidx, ld_blk, ark, inv_mix, rnd_en, busy, done, keys_valid
  );

  modport slave (
    input  start, key_new,
    output genk, kidx, ld_blk, ark, inv_mix, rnd_en, busy, done, keys_valid
  );
endinterface

// File: rtl/aes_round_ctr.sv
// Loadable up/down round-key index counter with a compare-to-value terminal flag.
module aes_round_ctr #(
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [KW-1:0] ld_val,
  input  logic          up,
  input  logic          en,
  input  logic [KW-1:0] tc_val,
  output logic [KW-1:0] cnt,
  output logic          tc
);
  logic [KW-1:0] cnt_reg;

  // Load has priority so a new sequence can restart the index mid-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (ld) begin
      cnt_reg <= ld_val;
    end else if (en) begin
      cnt_reg <= up ? cnt_reg + KW'(1) : cnt_reg - KW'(1);
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == tc_val);
endmodule

// File: rtl/aes_dec_cu.sv
// AES-128 inverse-cipher sequencer: optional key expansion, then round keys
// applied from rk[NR] down to rk[0]; the schedule is reused until key_new.
module aes_dec_cu import aes_pkg::*; #(
  parameter int NR = aes_pkg::NR,
  parameter int KW = aes_pkg::KW
) (
  input  logic        clk,
  input  logic        rst,
  aes_dec_cu_if.slave bus
);
  localparam logic [KW-1:0] K_NR  = KW'(NR);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  dec_state_t    state_reg, state_next;
  dec_ctl_t      ctl_reg;
  logic          keys_valid_reg, keys_valid_next;
  logic          ctr_ld, ctr_up, ctr_en, ctr_tc, accept;
  logic [KW-1:0] ctr_ld_val, ctr_tc_val, ctr_cnt;

  aes_round_ctr #(.KW(KW)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .ld     (ctr_ld),
    .ld_val (ctr_ld_val),
    .up     (ctr_up),
    .en     (ctr_en),
    .tc_val (ctr_tc_val),
    .cnt    (ctr_cnt),
    .tc     (ctr_tc)
  );

  assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);

  always_comb begin
    state_next      = state_reg;
    keys_valid_next = keys_valid_reg;
    ctr_ld          = 1'b0;
    ctr_ld_val      = K_NR;
    ctr_up          = 1'b0;
    ctr_en          = 1'b0;
    // Expansion stops at rk[NR]; the inverse rounds stop after rk[1].
    ctr_tc_val      = (state_reg == KEXP) ? K_NR : K_ONE;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept) begin
          ctr_ld = 1'b1;
          if (bus.key_new || !keys_valid_reg) begin
            state_next      = KEXP;
            ctr_ld_val      = K_ONE;
            keys_valid_next = 1'b0;
          end else begin
            state_next = LOAD;
          end
        end
      end
      KEXP: begin
        if (ctr_tc) begin
          state_next      = LOAD;
          ctr_ld          = 1'b1;
          keys_valid_next = 1'b1;
        end else begin
          ctr_en = 1'b1;
          ctr_up = 1'b1;
        end
      end
      LOAD: begin
        state_next = ROUND;
        ctr_en     = 1'b1;
      end
      ROUND: begin
        ctr_en = 1'b1;
        if (ctr_tc) state_next = LAST;
      end
      LAST:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      keys_valid_reg <= 1'b0;
      ctl_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      keys_valid_reg <= keys_valid_next;
      ctl_reg        <= ctl_decode(state_next);
    end
  end

  assign bus.genk       = ctl_reg.genk;
  assign bus.kidx       = ctr_cnt;
  assign bus.ld_blk     = ctl_reg.ld_blk;
  assign bus.ark        = ctl_reg.ark;
  assign bus.inv_mix    = ctl_reg.inv_mix;
  assign bus.rnd_en     = ctl_reg.rnd_en;
  assign bus.busy       = ctl_reg.busy;
  assign bus.done       = ctl_reg.done;
  assign bus.keys_valid = keys_valid_reg;
endmodule

// File: tb/tb_aes_dec_cu.sv
// Directed cycle-by-cycle check of the AES decrypt control sequence.
module tb_aes_dec_cu;
  localparam int S_IDLE  = 0;
  localparam int S_KEXP  = 1;
  localparam int S_LOAD  = 2;
  localparam int S_ROUND = 3;
  localparam int S_LAST  = 4;
  localparam int S_DONE  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  aes_dec_cu_if #(.KW(4)) bus ();

  aes_dec_cu #(.NR(10), .KW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for a state, taken straight from the strobe table.
  task automatic chk(input string tag, input int st, input int k, input bit kv);
    logic [11:0] obs, expv;
    obs  = {bus.genk, bus.ld_blk, bus.ark, bus.inv_mix, bus.rnd_en, bus.busy,
            bus.done, bus.keys_valid, bus.kidx};
    expv = {st == S_KEXP, st == S_LOAD, st == S_LOAD, st == S_ROUND,
            st == S_LOAD || st == S_ROUND || st == S_LAST,
            st == S_KEXP || st == S_LOAD || st == S_ROUND || st == S_LAST,
            st == S_DONE, kv, 4'(k)};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s st=%0d k=%0d: observed %h expected %h", tag, st, k, obs, expv);
    end
  endtask

  // Called one cycle after start was sampled; ends in the DONE cycle.
  task automatic run_block(input string tag, input bit expand, input bit inject);
    if (expand) begin
      for (int k = 1; k <= 10; k++) begin
        chk({tag, "_kexp"}, S_KEXP, k, 1'b0);
        step();
      end
    end
    chk({tag, "_load"}, S_LOAD, 10, 1'b1);
    step();
    for (int k = 9; k >= 1; k--) begin
      chk({tag, "_round"}, S_ROUND, k, 1'b1);
      if (inject) begin
        bus.start   = (k == 5);
        bus.key_new = (k == 5);
      end
      step();
    end
    chk({tag, "_last"}, S_LAST, 0, 1'b1);
    step();
    chk({tag, "_done"}, S_DONE, 0, 1'b1);
    $display("block %s: done sampled, expand=%0d", tag, expand);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.key_new = 1'b0;
    step();
    step();
    chk("reset", S_IDLE, 0, 1'b0);
    rst = 1'b0;
    step();
    chk("idle", S_IDLE, 0, 1'b0);

    // No schedule yet: expansion is forced even with key_new=0.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_block("first", 1'b1, 1'b0);
    step();
    chk("first_idle", S_IDLE, 0, 1'b1);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_block("cached", 1'b0, 1'b0);
    step();
    chk("cached_idle", S_IDLE, 0, 1'b1);

    // start held high: the next block begins straight out of DONE.
    bus.start = 1'b1;
    step();
    run_block("b2b_a", 1'b0, 1'b0);
    step();
    run_block("b2b_b", 1'b0, 1'b0);
    bus.start = 1'b0;
    step();
    chk("b2b_idle", S_IDLE, 0, 1'b1);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_block("ignore", 1'b0, 1'b1);
    step();
    chk("ignore_idle", S_IDLE, 0, 1'b1);

    bus.key_new = 1'b1;
    step();
    bus.key_new = 1'b0;
    chk("keynew_only", S_IDLE, 0, 1'b1);

    // key_new forces a fresh expansion, then reset aborts it at kidx=5.
    bus.start   = 1'b1;
    bus.key_new = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.key_new = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("abort_kexp", S_KEXP, k, 1'b0);
      if (k < 5) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rst", S_IDLE, 0, 1'b0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_block("reexp", 1'b1, 1'b0);
    step();
    chk("reexp_idle", S_IDLE, 0, 1'b1);

    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_start", S_IDLE, 0, 1'b0);
    step();
    chk("rst_start_hold", S_IDLE, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
